// File: rtl/femto_mem_pkg.sv
// femto_mem_pkg: shared owner encodings and response tag type for the unified memory port.
package femto_mem_pkg;
  localparam int MEM_LAT_MAX = 4;
  typedef enum logic {REQ_I = 1'b0, REQ_D = 1'b1} owner_e;
  typedef struct packed {
    logic   valid;
    owner_e owner;
  } tag_t;
endpackage

// File: rtl/mem_resp_tag_pipe.sv
// mem_resp_tag_pipe: DEPTH-stage tag shift register that tracks read owners through the memory latency.
module mem_resp_tag_pipe
  import femto_mem_pkg::*;
#(
  parameter int DEPTH = 1
) (
  input  logic clk,
  input  logic rst,
  input  tag_t din,
  output tag_t dout
);
  tag_t [DEPTH-1:0] pipe;
  always_ff @(posedge clk) begin
    if (rst) pipe <= '0;
    else begin
      pipe[0] <= din;
      for (int k = 1; k < DEPTH; k++) pipe[k] <= pipe[k-1];
    end
  end
  assign dout = pipe[DEPTH-1];
endmodule

// File: rtl/mem_port_arbiter.sv
// mem_port_arbiter: shares one memory port between fetch and load/store with bounded data priority.
module mem_port_arbiter
  import femto_mem_pkg::*;
#(
  parameter int ADDR_W     = 32,
  parameter int DATA_W     = 32,
  parameter int MEM_LAT    = 1,
  parameter int STARVE_MAX = 3
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                i_req,
  input  logic [ADDR_W-1:0]   i_addr,
  output logic                i_gnt,
  output logic                i_rvalid,
  output logic [DATA_W-1:0]   i_rdata,
  input  logic                d_req,
  input  logic                d_we,
  input  logic [DATA_W/8-1:0] d_be,
  input  logic [ADDR_W-1:0]   d_addr,
  input  logic [DATA_W-1:0]   d_wdata,
  output logic                d_gnt,
  output logic                d_rvalid,
  output logic [DATA_W-1:0]   d_rdata,
  output logic                m_en,
  output logic [DATA_W/8-1:0] m_we,
  output logic [ADDR_W-3:0]   m_addr,
  output logic [DATA_W-1:0]   m_wdata,
  input  logic [DATA_W-1:0]   m_rdata
);
  logic [3:0]        starve_cnt;
  logic              pick_i;
  tag_t              tag_in, tag_out;
  logic [DATA_W-1:0] i_rdata_q, d_rdata_q;
  logic              unused_addr_lsbs;
  assign unused_addr_lsbs = ^{i_addr[1:0], d_addr[1:0]};
  mem_resp_tag_pipe #(.DEPTH(MEM_LAT)) u_tag_pipe (
    .clk  (clk),
    .rst  (rst),
    .din  (tag_in),
    .dout (tag_out)
  );
  always_comb begin
    pick_i       = i_req & (~d_req | (starve_cnt == 4'(STARVE_MAX)));
    i_gnt        = ~rst & pick_i;
    d_gnt        = ~rst & d_req & ~pick_i;
    m_en         = i_gnt | d_gnt;
    m_addr       = i_gnt ? i_addr[ADDR_W-1:2] : d_addr[ADDR_W-1:2];
    m_we         = (d_gnt & d_we) ? d_be : '0;
    m_wdata      = d_gnt ? d_wdata : '0;
    tag_in.valid = m_en & ~(d_gnt & d_we);
    tag_in.owner = d_gnt ? REQ_D : REQ_I;
    i_rvalid     = tag_out.valid & (tag_out.owner == REQ_I);
    d_rvalid     = tag_out.valid & (tag_out.owner == REQ_D);
    i_rdata      = i_rvalid ? m_rdata : i_rdata_q;
    d_rdata      = d_rvalid ? m_rdata : d_rdata_q;
  end
  // the count only runs while fetch is actually waiting behind data grants
  always_ff @(posedge clk) begin
    if (rst || i_gnt || !i_req) starve_cnt <= '0;
    else if (d_gnt && starve_cnt != 4'(STARVE_MAX)) starve_cnt <= starve_cnt + 4'd1;
    if (i_rvalid) i_rdata_q <= m_rdata;
    if (d_rvalid) d_rdata_q <= m_rdata;
  end
endmodule

// File: tb/tb_mem_port_arbiter.sv
// tb_mem_port_arbiter: directed vector bench with a byte-enable memory model and response schedule.
module tb_mem_port_arbiter;
  localparam int LAT = 3;
  typedef struct {
    logic        ir, dr, dwe;
    logic [3:0]  be;
    logic [31:0] ia, da, wd;
    logic        eig, edg;
    logic [3:0]  ewe;
    logic [29:0] ea;
    logic [31:0] ewd, rd;
  } vec_t;
  logic clk = 0, rst = 1;
  logic i_req = 0, d_req = 0, d_we = 0;
  logic [3:0] d_be = '0;
  logic [31:0] i_addr = '0, d_addr = '0, d_wdata = '0;
  logic i_gnt, i_rvalid, d_gnt, d_rvalid, m_en;
  logic [31:0] i_rdata, d_rdata, m_wdata, m_rdata;
  logic [3:0] m_we;
  logic [29:0] m_addr;
  logic [31:0] mem [256];
  logic [31:0] rpipe [LAT];
  logic sv [512];
  logic so [512];
  logic [31:0] sd [512];
  int cyc = 0, total = 0, passed = 0;
  vec_t vq[$];
  always #5 clk = ~clk;
  mem_port_arbiter #(.ADDR_W(32), .DATA_W(32), .MEM_LAT(LAT), .STARVE_MAX(3)) dut (
    .clk(clk), .rst(rst),
    .i_req(i_req), .i_addr(i_addr), .i_gnt(i_gnt), .i_rvalid(i_rvalid), .i_rdata(i_rdata),
    .d_req(d_req), .d_we(d_we), .d_be(d_be), .d_addr(d_addr), .d_wdata(d_wdata),
    .d_gnt(d_gnt), .d_rvalid(d_rvalid), .d_rdata(d_rdata),
    .m_en(m_en), .m_we(m_we), .m_addr(m_addr), .m_wdata(m_wdata), .m_rdata(m_rdata)
  );
  function automatic logic [31:0] init_word(int k);
    return {8'hC0, 8'(k), 8'h5A, 8'(k)};
  endfunction
  assign m_rdata = rpipe[LAT-1];
  always @(posedge clk) begin
    if (rst) for (int k = 0; k < 256; k++) mem[k] <= init_word(k);
    else if (m_en)
      for (int b = 0; b < 4; b++) if (m_we[b]) mem[m_addr[7:0]][8*b +: 8] <= m_wdata[8*b +: 8];
    rpipe[0] <= mem[m_addr[7:0]];
    for (int k = 1; k < LAT; k++) rpipe[k] <= rpipe[k-1];
  end
  function automatic vec_t mk(logic ir, logic dr, logic dwe, logic [3:0] be, logic [31:0] ia,
                              logic [31:0] da, logic [31:0] wd, logic eig, logic edg,
                              logic [3:0] ewe, logic [29:0] ea, logic [31:0] ewd, logic [31:0] rd);
    vec_t v;
    v.ir = ir; v.dr = dr; v.dwe = dwe; v.be = be; v.ia = ia; v.da = da; v.wd = wd;
    v.eig = eig; v.edg = edg; v.ewe = ewe; v.ea = ea; v.ewd = ewd; v.rd = rd;
    return v;
  endfunction
  task automatic chk(string nm, logic [63:0] got, logic [63:0] exp);
    total++;
    if (got !== exp) $display("FAIL %s cycle %0d: got %h expected %h", nm, cyc, got, exp);
    else passed++;
  endtask
  task automatic resp_chk();
    chk("rvalid", 64'({i_rvalid, d_rvalid}), sv[cyc] ? (so[cyc] ? 64'b01 : 64'b10) : 64'b00);
    if (sv[cyc] && !so[cyc] && i_rvalid) chk("i_rdata", 64'(i_rdata), 64'(sd[cyc]));
    if (sv[cyc] && so[cyc] && d_rvalid) chk("d_rdata", 64'(d_rdata), 64'(sd[cyc]));
  endtask
  task automatic apply(vec_t v);
    i_req = v.ir; d_req = v.dr; d_we = v.dwe; d_be = v.be;
    i_addr = v.ia; d_addr = v.da; d_wdata = v.wd;
    @(negedge clk);
    chk("gnt", 64'({i_gnt, d_gnt}), 64'({v.eig, v.edg}));
    chk("m_en", 64'(m_en), 64'(v.eig | v.edg));
    chk("m_we", 64'(m_we), 64'(v.ewe));
    if (v.eig | v.edg) begin
      chk("m_addr", 64'(m_addr), 64'(v.ea));
      chk("m_wdata", 64'(m_wdata), 64'(v.ewd));
    end
    resp_chk();
    if (v.eig | (v.edg & ~v.dwe)) begin
      sv[cyc+LAT] = 1'b1; so[cyc+LAT] = v.edg; sd[cyc+LAT] = v.rd;
    end
    @(posedge clk); cyc++; #1;
  endtask
  task automatic reset_cycle();
    rst = 1; i_req = 1; d_req = 1; d_we = 1; d_be = 4'hF;
    @(negedge clk);
    chk("rst_gnt", 64'({i_gnt, d_gnt}), 64'b00);
    chk("rst_m_en", 64'(m_en), 64'b0);
    chk("rst_m_we", 64'(m_we), 64'b0);
    for (int k = cyc + 1; k < 512; k++) sv[k] = 1'b0;
    @(posedge clk); cyc++; #1;
    rst = 0; i_req = 0; d_req = 0; d_we = 0; d_be = '0;
  endtask
  task automatic idle(int n);
    for (int k = 0; k < n; k++) apply(mk(0,0,0,4'h0,0,0,0, 0,0,4'h0,30'h0,0,0));
  endtask
  initial begin
    for (int k = 0; k < 512; k++) begin sv[k] = 1'b0; so[k] = 1'b0; sd[k] = '0; end
    @(posedge clk); #1;
    reset_cycle();
    reset_cycle();
    // fetch only, back to back
    vq.push_back(mk(1,0,0,4'h0,32'h00,0,0, 1,0,4'h0,30'h0,0,32'hC0005A00));
    vq.push_back(mk(1,0,0,4'h0,32'h04,0,0, 1,0,4'h0,30'h1,0,32'hC0015A01));
    vq.push_back(mk(1,0,0,4'h0,32'h08,0,0, 1,0,4'h0,30'h2,0,32'hC0025A02));
    // continuous contention: D,D,D,I,D,D,D,I
    vq.push_back(mk(1,1,0,4'h0,32'h40,32'h80,0, 0,1,4'h0,30'h20,0,32'hC0205A20));
    vq.push_back(mk(1,1,0,4'h0,32'h40,32'h84,0, 0,1,4'h0,30'h21,0,32'hC0215A21));
    vq.push_back(mk(1,1,0,4'h0,32'h40,32'h88,0, 0,1,4'h0,30'h22,0,32'hC0225A22));
    vq.push_back(mk(1,1,0,4'h0,32'h40,32'h8C,0, 1,0,4'h0,30'h10,0,32'hC0105A10));
    vq.push_back(mk(1,1,0,4'h0,32'h44,32'h8C,0, 0,1,4'h0,30'h23,0,32'hC0235A23));
    vq.push_back(mk(1,1,0,4'h0,32'h44,32'h90,0, 0,1,4'h0,30'h24,0,32'hC0245A24));
    vq.push_back(mk(1,1,0,4'h0,32'h44,32'h94,0, 0,1,4'h0,30'h25,0,32'hC0255A25));
    vq.push_back(mk(1,1,0,4'h0,32'h44,32'h98,0, 1,0,4'h0,30'h11,0,32'hC0115A11));
    // partial store then load of the same word
    vq.push_back(mk(0,1,1,4'h3,0,32'h10,32'hDEADBEEF, 0,1,4'h3,30'h4,32'hDEADBEEF,0));
    vq.push_back(mk(0,1,0,4'h0,0,32'h10,0, 0,1,4'h0,30'h4,0,32'hC004BEEF));
    // simultaneous request below the starvation limit
    vq.push_back(mk(1,1,0,4'h0,32'h24,32'h20,0, 0,1,4'h0,30'h8,0,32'hC0085A08));
    vq.push_back(mk(1,0,0,4'h0,32'h24,0,0, 1,0,4'h0,30'h9,0,32'hC0095A09));
    // zero byte-enable store
    vq.push_back(mk(0,1,1,4'h0,0,32'h30,32'h12345678, 0,1,4'h0,30'hC,32'h12345678,0));
    foreach (vq[k]) apply(vq[k]);
    idle(LAT + 1);
    // reset with two reads in flight and starve count at 2
    apply(mk(1,1,0,4'h0,32'h04,32'h00,0, 0,1,4'h0,30'h0,0,32'hC0005A00));
    apply(mk(1,1,0,4'h0,32'h04,32'h08,0, 0,1,4'h0,30'h2,0,32'hC0025A02));
    reset_cycle();
    apply(mk(1,1,0,4'h0,32'h04,32'h0C,0, 0,1,4'h0,30'h3,0,32'hC0035A03));
    apply(mk(1,1,0,4'h0,32'h04,32'h10,0, 0,1,4'h0,30'h4,0,32'hC0045A04));
    apply(mk(1,1,0,4'h0,32'h04,32'h14,0, 0,1,4'h0,30'h5,0,32'hC0055A05));
    apply(mk(1,1,0,4'h0,32'h04,32'h18,0, 1,0,4'h0,30'h1,0,32'hC0015A01));
    idle(LAT + 1);
    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end
endmodule
